// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_tx
// Purpose  : Serial bit-pattern transmitter. On a start request it latches a
//            parallel pattern and shifts it out MSB-first, one bit per clock,
//            repeating the frame max(repeat_cnt,1) times with GAP idle cycles
//            between frames. All outputs are registered.
// Ports    : clock      - rising-edge clock
//            reset      - synchronous, active-high reset
//            start      - job request, sampled only in IDLE
//            pattern    - frame contents, bit WIDTH-1 sent first
//            repeat_cnt - frames to send (0 treated as 1)
//            out        - serial bit
//            valid      - out carries a frame bit this cycle
//            busy       - transmission in progress (SHIFT or GAP)
//            done       - one-cycle pulse after the final bit
// Options  : SERIAL_PATTERN_TX_PARITY_EN - when defined, append one even-parity
//            bit (XOR of the latched pattern) after bit 0 of every frame.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] c_idx_msb  = IDX_W'(WIDTH - 1);
  // Gap counter is loaded with GAP-1 so the GAP state lasts exactly GAP cycles.
  localparam logic [3:0]       c_gap_last = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [3:0]       gap_q, gap_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             frame_end_w;
  logic [IDX_W-1:0] idx_dec_w;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic             par_q, par_d;
  // The frame ends after the parity cycle, not after bit 0.
  assign frame_end_w = par_q;
`else
  assign frame_end_w = (idx_q == '0);
`endif

  assign idx_dec_w = idx_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    idx_d    = idx_q;
    frames_d = frames_q;
    gap_d    = gap_q;
    out_d    = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Outputs are registered, so the first bit is driven from the
          // incoming pattern to appear right after the accepting edge.
          pat_d    = pattern;
          frames_d = (repeat_cnt == '0) ? c_one : repeat_cnt;
          idx_d    = c_idx_msb;
          state_d  = S_SHIFT;
          out_d    = pattern[WIDTH-1];
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end

      S_SHIFT: begin
        if (frame_end_w) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          par_d = 1'b0;
`endif
          if (frames_q > c_one) begin
            frames_d = frames_q - c_one;
            busy_d   = 1'b1;
            if (GAP > 0) begin
              gap_d   = c_gap_last;
              state_d = S_GAP;
            end else begin
              idx_d   = c_idx_msb;
              out_d   = pat_q[WIDTH-1];
              valid_d = 1'b1;
            end
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        end else if (idx_q == '0) begin
          par_d   = 1'b1;
          out_d   = ^pat_q;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`endif
        end else begin
          idx_d   = idx_dec_w;
          out_d   = pat_q[idx_dec_w];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_GAP: begin
        busy_d = 1'b1;
        if (gap_q == 4'd0) begin
          state_d = S_SHIFT;
          idx_d   = c_idx_msb;
          out_d   = pat_q[WIDTH-1];
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      idx_q    <= '0;
      frames_q <= '0;
      gap_q    <= 4'd0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      idx_q    <= idx_d;
      frames_q <= frames_d;
      gap_q    <= gap_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_tx
// Purpose  : Self-checking bench for serial_pattern_tx. Two instances (GAP=0
//            and GAP=2) share clock, reset, pattern and repeat_cnt; each has
//            its own start. Expected per-cycle outputs are queued when a job
//            is launched and compared every cycle; an empty queue means idle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int TB_L   = 5;
  localparam bit TB_PAR = 1'b1;
`else
  localparam int TB_L   = 4;
  localparam bit TB_PAR = 1'b0;
`endif

  typedef struct packed {
    logic o;
    logic v;
    logic b;
    logic d;
  } obs_t;

  typedef struct {
    int         inst;
    logic [3:0] pat;
    logic [3:0] rep;
    int         exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [3:0] pattern = 4'd0;
  logic [3:0] repeat_cnt = 4'd0;
  logic       o0, v0, b0, d0;
  logic       o1, v1, b1, d1;

  obs_t q0[$];
  obs_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP(0)) u0 (
    .clock(clk), .reset(rst), .start(start0), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .out(o0), .valid(v0), .busy(b0), .done(d0)
  );

  serial_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP(2)) u1 (
    .clock(clk), .reset(rst), .start(start1), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .out(o1), .valid(v1), .busy(b1), .done(d1)
  );

  task automatic push(input int inst, input obs_t e);
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  // Reference model: expected output tuple for every cycle after the
  // accepting edge, ending with the done pulse.
  task automatic push_job(input int inst, input logic [3:0] p, input logic [3:0] r);
    int f_n;
    int gap;
    f_n = (r == 4'd0) ? 1 : int'(r);
    gap = (inst == 0) ? 0 : 2;
    for (int f = 0; f < f_n; f++) begin
      for (int i = 3; i >= 0; i--) push(inst, '{o: p[i], v: 1'b1, b: 1'b1, d: 1'b0});
      if (TB_PAR) push(inst, '{o: ^p, v: 1'b1, b: 1'b1, d: 1'b0});
      if (f < f_n - 1)
        for (int g = 0; g < gap; g++) push(inst, '{o: 1'b0, v: 1'b0, b: 1'b1, d: 1'b0});
    end
    push(inst, '{o: 1'b0, v: 1'b0, b: 1'b0, d: 1'b1});
  endtask

  task automatic check(input int inst, input obs_t act);
    obs_t e;
    e = '0;
    if (inst == 0) begin
      if (q0.size() > 0) e = q0.pop_front();
    end else begin
      if (q1.size() > 0) e = q1.pop_front();
    end
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL cycle_u%0d t=%0t got {out,valid,busy,done}=%b want %b",
               inst, $time, act, e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      check(0, '{o: o0, v: v0, b: b0, d: d0});
      check(1, '{o: o1, v: v1, b: b1, d: d1});
    end
  end

  task automatic set_start(input int inst, input logic val);
    if (inst == 0) start0 = val;
    else           start1 = val;
  endtask

  // Launch one job, then measure edges from the accepting edge to done.
  task automatic run_job(input int inst, input logic [3:0] p, input logic [3:0] r,
                         input int exp_d);
    int  n;
    bit  got;
    @(negedge clk);
    pattern    = p;
    repeat_cnt = r;
    push_job(inst, p, r);
    set_start(inst, 1'b1);
    @(posedge clk);
    #1;
    set_start(inst, 1'b0);
    n   = 1;
    got = (inst == 0) ? d0 : d1;
    while (!got && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      got = (inst == 0) ? d0 : d1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL done_timeout_u%0d no done within %0d cycles, required after %0d",
               inst, n, exp_d);
    end else if (n - 1 != exp_d) begin
      n_bad++;
      $display("FAIL done_lat_u%0d got done after edge E0+%0d, required E0+%0d",
               inst, n - 1, exp_d);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int la;

    vecs[0] = '{inst: 0, pat: 4'b1011, rep: 4'd1,  exp_done: TB_L};
    vecs[1] = '{inst: 0, pat: 4'b1010, rep: 4'd3,  exp_done: 3 * TB_L};
    vecs[2] = '{inst: 1, pat: 4'b1100, rep: 4'd2,  exp_done: 2 * TB_L + 2};
    vecs[3] = '{inst: 1, pat: 4'b1100, rep: 4'd0,  exp_done: TB_L};
    vecs[4] = '{inst: 0, pat: 4'b0110, rep: 4'd0,  exp_done: TB_L};
    vecs[5] = '{inst: 1, pat: 4'b1001, rep: 4'd15, exp_done: 15 * TB_L + 14 * 2};
    vecs[6] = '{inst: 0, pat: 4'b1111, rep: 4'd2,  exp_done: 2 * TB_L};
    vecs[7] = '{inst: 0, pat: 4'b0001, rep: 4'd15, exp_done: 15 * TB_L};

    // Reset state: the monitor checks idle outputs while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 8; k++)
      run_job(vecs[k].inst, vecs[k].pat, vecs[k].rep, vecs[k].exp_done);

    // start toggling and pattern/repeat changes during a job are ignored.
    @(negedge clk);
    pattern    = 4'b1011;
    repeat_cnt = 4'd2;
    push_job(1, 4'b1011, 4'd2);
    la = q1.size();
    start1 = 1'b1;
    for (int k = 1; k < la; k++) begin
      @(negedge clk);
      start1     = k[0];
      pattern    = 4'b0000;
      repeat_cnt = 4'd15;
    end
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(posedge clk);

    // start held through DONE: ignored there, accepted one IDLE cycle later.
    @(negedge clk);
    pattern    = 4'b1010;
    repeat_cnt = 4'd1;
    push_job(0, 4'b1010, 4'd1);
    la = q0.size();
    push(0, '{o: 1'b0, v: 1'b0, b: 1'b0, d: 1'b0});
    push_job(0, 4'b0110, 4'd1);
    start0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pattern = 4'b0110;
    repeat (la) @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (TB_L + 4) @(posedge clk);

    // Reset mid-frame: job aborted, no done, next job runs normally.
    @(negedge clk);
    pattern    = 4'b1101;
    repeat_cnt = 4'd2;
    push_job(0, 4'b1101, 4'd2);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q0.delete();
    rst    = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    run_job(0, 4'b1001, 4'd1, TB_L);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time, required finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-pattern transmitter: the driving end of the single-bit serial input consumed by the team's clocked sequence-detector FSMs. On a start request it latches a parallel pattern and shifts it out MSB-first, one bit per clock, optionally repeating the frame with a configurable idle gap. It replaces hand-written `inp` toggling in detector benches and serves as the serial source in the integrated design.

## Interface
- `WIDTH`, 4: pattern length in bits (≥2)
- `CNT_W`, 4: width of repeat-count input
- `GAP`, 0: idle cycles inserted between repeated frames (0..15)

- `clock`  in  1  rising-edge clock
- `reset`  in  1  reset; synchronous and active-high
- `start`  in  1  request; sampled only in IDLE
- `pattern`  in  WIDTH  frame contents, bit WIDTH-1 sent first
- `repeat_cnt`  in  CNT_W  frames to send; 0 treated as 1
- `out`  out  1  serial bit (connects to detector `inp`)
- `valid`  out  1  `out` carries a frame bit this cycle
- `busy`  out  1  transmission in progress (SHIFT or GAP)
- `done`  out  1  one-cycle pulse after the final bit

## Operation
- States: IDLE, SHIFT, GAP, DONE. All outputs registered.
- IDLE: out=0, valid=0, busy=0. `start`=1 at an edge → latch `pattern` and `max(repeat_cnt,1)` into internal registers, bit index = WIDTH-1, enter SHIFT.
- SHIFT: out = latched[bit index], valid=1, busy=1; index decrements each edge. After bit 0 (or parity bit, see Configuration): if frames remain → GAP (GAP>0) or directly SHIFT for next frame (GAP=0); else → DONE.
- GAP: out=0, valid=0, busy=1 for exactly GAP cycles, then SHIFT with index reset to WIDTH-1.
- DONE: done=1, busy=0, valid=0, out=0 for one cycle; `start` ignored; → IDLE.
- `start`, `pattern`, `repeat_cnt` ignored outside IDLE; changes during transmission do not affect the current job.
- Frame counter counts down; width CNT_W, no wrap (loaded value ≤ 2^CNT_W-1).

## Timing
- Reset (any state, including mid-frame): next edge → IDLE, out=0, valid=0, busy=0, done=0, counters cleared; aborted job produces no `done`. Reset wins over `start` in the same cycle.
- Latency: `start` sampled at edge E0 → first bit on `out` valid after E0 (zero-bubble).
- Frame length L = WIDTH (WIDTH+1 with parity). Bit i of frame f (0-based) appears after edge E0 + f·(L+GAP) + i.
- `done` high for the cycle after edge E0 + F·L + (F-1)·GAP, F = frames sent.
- Earliest next accepted `start`: the edge following the DONE cycle (IDLE).
- GAP=0, F>1: frames back-to-back, valid continuously high for F·L cycles.

## Configuration
- `SERIAL_PATTERN_TX_PARITY_EN` defined: after bit 0 of every frame, one extra SHIFT cycle sends even parity (XOR of all latched pattern bits) with valid=1; L = WIDTH+1.
- Undefined: no parity cycle, L = WIDTH; parity logic absent.

## Test plan
- Reset then `pattern`=4'b1011, `repeat_cnt`=1, one-cycle `start` → out 1,0,1,1 over 4 cycles with valid=1, busy=1; done=1 on cycle 5; then IDLE, all outputs 0.
- `pattern`=4'b1010, `repeat_cnt`=3, GAP=0 → 12 continuous valid bits 101010101010; single done pulse after bit 12.
- GAP=2, `repeat_cnt`=2, `pattern`=4'b1100 → 1,1,0,0, two cycles valid=0/out=0, 1,1,0,0, done; `repeat_cnt`=0 → exactly one frame.
- During busy: toggle `start`, change `pattern` to 4'b0000 → current job unchanged, no second job launched; `start` held during DONE cycle ignored, accepted next cycle.
- Assert `reset` after bit 2 of a frame → next cycle out=0, valid=0, busy=0, no done; new `start` afterwards transmits normally.
- With `SERIAL_PATTERN_TX_PARITY_EN`: 4'b1011 → 1,0,1,1,1 (parity 1), done on cycle 6; 4'b1001 → 1,0,0,1,0.
